pid_pwm_driver: RTL
===================

Name: pid_pwm_driver

Overview:
- Downstream stage of the PID controller.
- Consumes the 8-bit clamped control word and produces a single-ended PWM output with a programmable tick prescaler.
- Duty updates are double-buffered: a shadow register is loaded at any time, and it is transferred to the active duty only at a period boundary, so pulses are never glitched.
- An enable/drain state machine makes start and stop period-aligned.

Parameters:
- PERIOD_MAX, 254, last counter value. A period is PERIOD_MAX+1 = 255 ticks, so duty 255 gives a fully-high output.
- DEAD_TICKS, 2, dead-time in clk cycles. Used only when PWM_DEADTIME_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- duty_in  in  8  new duty word (PID control_out)
- duty_valid  in  1  one-cycle strobe; duty_in is loaded into the shadow register
- div_in  in  8  prescaler divide value; tick every div_in+1 clocks
- enable  in  1  run request
- pwm_out  out  1  PWM output, registered
- period_start  out  1  one-cycle pulse on the first cycle of each period
- duty_active  out  8  duty currently applied
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on rst_n. Reset mid-operation immediately forces the following, regardless of state:
  - state=IDLE
  - cnt=0, prescaler=0
  - shadow=0, duty_active=0, div_active=0
  - pwm_out=0, period_start=0, busy=0
- Shadow register: duty_valid=1 loads shadow<=duty_in in any state, including IDLE.
- Prescaler:
  - In RUN/DRAIN it counts 0..div_active.
  - tick=1 when prescaler==div_active; the prescaler then wraps to 0.
  - div_in=0 gives a tick every clock.
- Counter:
  - cnt is 8 bits and advances on each tick.
  - It wraps PERIOD_MAX->0.
  - Boundary = tick && cnt==PERIOD_MAX.
- At boundary, all of the following happen together:
  - duty_active<=shadow. If duty_valid coincides with the boundary, duty_in is used directly (bypass) and shadow is also loaded.
  - div_active<=div_in.
  - period_start<=1 for the next cycle.
- pwm_out is registered: pwm_out<=(state!=IDLE)&&(cnt<duty_active). This gives one clock of latency after cnt/duty_active.
  - duty 0: output constantly low.
  - duty 255: output constantly high, because cnt never exceeds 254.
  - duty N with div_in=0: N clocks high, 255-N clocks low.
- State machine:
  - IDLE: cnt=0, prescaler=0, pwm_out=0.
    - enable=1 -> RUN. On the transition cycle: duty_active<=shadow (or duty_in if duty_valid is high the same cycle), div_active<=div_in, period_start pulses next cycle.
  - RUN: normal operation.
    - enable=0 -> DRAIN.
  - DRAIN: continues the current period unchanged.
    - enable=1 -> RUN, with no period restart.
    - Boundary with enable=0 -> IDLE. No period_start is issued and pwm_out goes 0.
    - If enable=1 and the boundary occur in the same cycle, enable wins: RUN and normal boundary update.
- busy=1 in RUN or DRAIN.
- Reserved state encodings -> IDLE.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- When defined:
  - Adds output port pwm_out_n (out, 1).
  - Adds gated high-side output pwm_hs.
  - Each rising transition of the raw PWM delays pwm_hs rising by DEAD_TICKS clocks. pwm_out_n falls immediately.
  - Each falling transition delays pwm_out_n rising by DEAD_TICKS clocks. pwm_hs falls immediately.
  - pwm_hs and pwm_out_n are never high together.
  - pwm_out is driven by pwm_hs.
  - Pulses shorter than DEAD_TICKS are suppressed.
  - In IDLE both outputs are 0.
- When undefined:
  - No pwm_out_n port and no dead-time logic.
  - pwm_out is the raw registered compare.

Test Plan:
1. Reset, shadow=128 via duty_valid, div_in=0, enable=1 -> period_start pulse, then pwm_out high 128 clocks and low 127 clocks, repeating every 255 clocks.
2. duty 0 and duty 255 (div_in=0) -> pwm_out constant 0 and constant 1 respectively across 3 periods; period_start every 255 clocks.
3. Running at duty 64, duty_valid with 200 at cnt=100 -> current period keeps 64 high clocks; next period has 200 high clocks; duty_active changes exactly at the boundary. duty_valid with 10 on the boundary cycle -> duty_active=10 the next period.
4. div_in=3, duty 10 -> 40 clocks high per 1020-clock period. div_in changed mid-period -> takes effect only at the next boundary.
5. enable dropped at cnt=50 -> busy stays 1 until the boundary, then IDLE with pwm_out=0 and no period_start. Separately, enable re-raised at cnt=200 of DRAIN -> continuous output. Separately, rst_n pulsed mid-high-pulse -> pwm_out=0 and duty_active=0 asynchronously.
6. With PWM_DEADTIME_EN, DEAD_TICKS=2, duty 100, div_in=0 -> pwm_hs high 98 clocks, pwm_out_n high 153 clocks, both low for 2 clocks at each edge, never simultaneously high.

Source files
------------

// File: rtl/pid_pwm_driver.sv
// Double-buffered PWM stage with a tick prescaler and period-aligned start/stop.
// Define PWM_DEADTIME_EN to add the dead-time gated complementary output pair (pwm_out_n).
module pid_pwm_driver #(
    parameter int unsigned PERIOD_MAX = 254
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DEAD_TICKS = 2
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    input  logic [7:0] div_in,
    input  logic       enable,
    output logic       pwm_out,
`ifdef PWM_DEADTIME_EN
    output logic       pwm_out_n,
`endif
    output logic       period_start,
    output logic [7:0] duty_active,
    output logic       busy
);

    // state   | meaning
    // S_IDLE  | stopped, counters held at 0, output low
    // S_RUN   | normal PWM generation
    // S_DRAIN | stop requested, finishing the current period
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] C_PMAX = 8'(PERIOD_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] r_presc;
    logic [7:0] r_shadow;
    logic [7:0] r_duty_active;
    logic [7:0] r_div_active;
    logic       r_pwm;
    logic       r_period_start;

    logic       w_active;
    logic       w_tick;
    logic       w_boundary;
    logic       w_load;
    logic [7:0] w_duty_nxt;

    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_tick     = w_active && (r_presc == r_div_active);
    assign w_boundary = w_tick && (r_cnt == C_PMAX);
    // A strobe landing on the load cycle bypasses the shadow register.
    assign w_duty_nxt = duty_valid ? duty_in : r_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                w_state_nxt = enable ? S_RUN : S_DRAIN;
                w_load      = w_boundary;
            end
            S_DRAIN: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                    w_load      = w_boundary;
                end else if (w_boundary) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= 8'd0;
            r_presc        <= 8'd0;
            r_shadow       <= 8'd0;
            r_duty_active  <= 8'd0;
            r_div_active   <= 8'd0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            if (duty_valid) begin
                r_shadow <= duty_in;
            end
            r_period_start <= w_load;
            if (w_load) begin
                r_duty_active <= w_duty_nxt;
                r_div_active  <= div_in;
            end
            if (!w_active || (w_state_nxt == S_IDLE)) begin
                r_cnt   <= 8'd0;
                r_presc <= 8'd0;
            end else if (w_tick) begin
                r_presc <= 8'd0;
                r_cnt   <= (r_cnt == C_PMAX) ? 8'd0 : r_cnt + 8'd1;
            end else begin
                r_presc <= r_presc + 8'd1;
            end
            r_pwm <= w_active && (r_cnt < r_duty_active);
        end
    end

`ifdef PWM_DEADTIME_EN
    // Window of the current raw level plus the previous DEAD_TICKS levels; an
    // output only asserts once its level has been stable across the whole window.
    logic [DEAD_TICKS-1:0] r_hist;
    logic [DEAD_TICKS:0]   w_win;
    logic                  r_hs;
    logic                  r_ls;

    assign w_win = {r_hist, r_pwm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_hs   <= 1'b0;
            r_ls   <= 1'b0;
        end else begin
            r_hist <= w_win[DEAD_TICKS-1:0];
            r_hs   <= &w_win;
            r_ls   <= w_active && ~|w_win;
        end
    end

    assign pwm_out   = r_hs;
    assign pwm_out_n = r_ls;
`else
    assign pwm_out = r_pwm;
`endif

    assign period_start = r_period_start;
    assign duty_active  = r_duty_active;
    assign busy         = w_active;

endmodule
